led_pwm_driver: RTL and testbench



---
 rtl/led_pwm_driver_pkg.sv | 18 +
 rtl/led_pwm_driver_pwm_core.sv | 45 ++++
 rtl/led_pwm_driver.sv | 159 +++++++++++++++
 tb/tb_led_pwm_driver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_driver_pkg.sv
// Shared encodings for the LED PWM driver: animation FSM states and mode selects.
package led_pkg;

    typedef enum logic [1:0] {
        HOLD_LOW  = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD_HIGH = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

endpackage

// File: rtl/led_pwm_driver_pwm_core.sv
// PWM engine: clock divider, free-running PWM counter, period-aligned duty latch
// and the registered LED comparator.
module pwm_core #(
    parameter int PWM_BITS = 8,
    parameter int PWM_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PWM_BITS-1:0] level,
    output logic                led,
    output logic                period_end
);

    localparam int DW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [DW-1:0]       div_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_q;
    logic                pwm_tick;

    assign pwm_tick   = (div_cnt == DW'(PWM_DIV - 1));
    assign period_end = pwm_tick && (pwm_cnt == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
            duty_q  <= '0;
            led     <= 1'b0;
        end else begin
            div_cnt <= pwm_tick ? '0 : div_cnt + 1'b1;
            if (pwm_tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            // Duty only changes at the period boundary so a period is never split.
            if (period_end) begin
                duty_q <= level;
            end
            led <= en && ((duty_q == MAX) || (duty_q > pwm_cnt));
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// LED output stage: mode tracking, step/hold timing and the brightness animation
// FSM (blink / breathe) feeding the PWM engine.
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int PWM_DIV      = 4,
    parameter int STEP_PERIODS = 2,
    parameter int HOLD_STEPS   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    output logic                led,
    output logic [PWM_BITS-1:0] level,
    output logic [1:0]          state,
    output logic                period_end
);

    localparam int SW = $clog2(STEP_PERIODS + 1);
    localparam int HW = $clog2(HOLD_STEPS + 1);
    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [PWM_BITS-1:0] MAX_M1 = MAX - 1'b1;

    mode_t               mode_in, mode_q;
    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] level_d;
    logic [SW-1:0]       step_cnt, step_d;
    logic [HW-1:0]       hold_cnt, hold_d;
    logic                step_fire;
    logic                hold_done;

    assign mode_in   = mode_t'(mode);
    assign hold_done = (hold_cnt == HW'(HOLD_STEPS - 1));
    assign state     = state_q;

    pwm_core #(
        .PWM_BITS (PWM_BITS),
        .PWM_DIV  (PWM_DIV)
    ) u_pwm_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .level      (level),
        .led        (led),
        .period_end (period_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            state_q  <= HOLD_LOW;
            level    <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            mode_q   <= mode_in;
            state_q  <= state_d;
            level    <= level_d;
            step_cnt <= step_d;
            hold_cnt <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level;
        step_d    = step_cnt;
        hold_d    = hold_cnt;
        step_fire = 1'b0;

        // A mode change restarts the animation even while disabled and beats a step.
        if (mode_in != mode_q) begin
            step_d = '0;
            hold_d = '0;
            if (mode_in == MODE_ON) begin
                state_d = HOLD_HIGH;
                level_d = MAX;
            end else begin
                state_d = HOLD_LOW;
                level_d = '0;
            end
        end else if (mode_q == MODE_OFF) begin
            state_d = HOLD_LOW;
            level_d = '0;
            step_d  = '0;
            hold_d  = '0;
        end else if (mode_q == MODE_ON) begin
            state_d = HOLD_HIGH;
            level_d = MAX;
            step_d  = '0;
            hold_d  = '0;
        end else if (en && period_end) begin
            if (step_cnt == SW'(STEP_PERIODS - 1)) begin
                step_d    = '0;
                step_fire = 1'b1;
            end else begin
                step_d = step_cnt + 1'b1;
            end
        end

        if (step_fire) begin
            case (state_q)
                HOLD_LOW: begin
                    level_d = '0;
                    if (hold_done) begin
                        hold_d = '0;
                        if (mode_q == MODE_BLINK) begin
                            state_d = HOLD_HIGH;
                            level_d = MAX;
                        end else begin
                            state_d = RAMP_UP;
                        end
                    end else begin
                        hold_d = hold_cnt + 1'b1;
                    end
                end
                HOLD_HIGH: begin
                    level_d = MAX;
                    if (hold_done) begin
                        hold_d = '0;
                        if (mode_q == MODE_BLINK) begin
                            state_d = HOLD_LOW;
                            level_d = '0;
                        end else begin
                            state_d = RAMP_DOWN;
                        end
                    end else begin
                        hold_d = hold_cnt + 1'b1;
                    end
                end
                RAMP_UP: begin
                    hold_d = '0;
                    if (mode_q == MODE_BLINK) begin
                        state_d = HOLD_LOW;
                        level_d = '0;
                    end else if (level >= MAX_M1) begin
                        state_d = HOLD_HIGH;
                        level_d = MAX;
                    end else begin
                        level_d = level + 1'b1;
                    end
                end
                default: begin
                    hold_d = '0;
                    // Saturating descent: anything at or below 1 lands on 0.
                    if ((mode_q == MODE_BLINK) || (level <= 1)) begin
                        state_d = HOLD_LOW;
                        level_d = '0;
                    end else begin
                        level_d = level - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Randomized scoreboard bench for led_pwm_driver against a step-indexed
// behavioural model of the blink/breathe animation and PWM waveform.
module tb_led_pwm_driver;

    localparam int PB    = 4;
    localparam int PD    = 2;
    localparam int SP    = 1;
    localparam int HS    = 2;
    localparam int MAXV  = (1 << PB) - 1;
    localparam int PER   = PD * (1 << PB);
    localparam int BCYC  = 2 * HS + 2 * MAXV;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [1:0]    mode;
    logic          led;
    logic [PB-1:0] level;
    logic [1:0]    state;
    logic          period_end;

    logic [7:0] exp_q[$];
    int         chk_cnt  = 0;
    int         pass_cnt = 0;

    // model: position in period, latched duty, led, registered mode, steps since restart
    int m_pos, m_duty, m_led, m_mode_q, m_nstep, m_pc;

    led_pwm_driver #(
        .PWM_BITS     (PB),
        .PWM_DIV      (PD),
        .STEP_PERIODS (SP),
        .HOLD_STEPS   (HS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .led        (led),
        .level      (level),
        .state      (state),
        .period_end (period_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int seq_state(input int md, input int n);
        int c;
        case (md)
            0: return 0;
            1: return 2;
            2: return ((n % (2 * HS)) < HS) ? 0 : 2;
            default: begin
                c = n % BCYC;
                if (c < HS) return 0;
                if (c < HS + MAXV) return 1;
                if (c < 2 * HS + MAXV) return 2;
                return 3;
            end
        endcase
    endfunction

    function automatic int seq_level(input int md, input int n);
        int c;
        case (md)
            0: return 0;
            1: return MAXV;
            2: return ((n % (2 * HS)) < HS) ? 0 : MAXV;
            default: begin
                c = n % BCYC;
                if (c < HS) return 0;
                if (c < HS + MAXV) return c - HS;
                if (c < 2 * HS + MAXV) return MAXV;
                return MAXV - (c - 2 * HS - MAXV);
            end
        endcase
    endfunction

    function automatic logic [7:0] model_out();
        logic [7:0] v;
        v[7]   = (m_pos == PER - 1);
        v[6]   = m_led[0];
        v[5:4] = 2'(seq_state(m_mode_q, m_nstep));
        v[3:0] = 4'(seq_level(m_mode_q, m_nstep));
        return v;
    endfunction

    task automatic model_reset();
        m_pos    = 0;
        m_duty   = 0;
        m_led    = 0;
        m_mode_q = 0;
        m_nstep  = 0;
        m_pc     = 0;
    endtask

    task automatic model_step(input int en_i, input int md_i);
        int pe;
        int cur_lvl;
        pe      = (m_pos == PER - 1);
        cur_lvl = seq_level(m_mode_q, m_nstep);
        m_led   = (en_i != 0) && (m_duty == MAXV || m_pos < m_duty * PD);
        if (pe) m_duty = cur_lvl;
        if (md_i != m_mode_q) begin
            m_nstep = 0;
            m_pc    = 0;
        end else if (m_mode_q >= 2 && en_i != 0 && pe) begin
            m_pc++;
            if (m_pc == SP) begin
                m_pc = 0;
                m_nstep++;
            end
        end
        m_pos    = (m_pos + 1) % PER;
        m_mode_q = md_i;
    endtask

    task automatic check(input string nm, input int got, input int exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s t=%0t got=0x%0h expected=0x%0h", nm, $time, got, exp);
    endtask

    task automatic cycle(input logic e, input logic [1:0] md);
        en   = e;
        mode = md;
        model_step(int'(e), int'(md));
        exp_q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic run_until(input logic [1:0] md, input int lvl, input int st);
        int n = 0;
        while (!(seq_level(m_mode_q, m_nstep) == lvl &&
                 (st < 0 || seq_state(m_mode_q, m_nstep) == st)) && n < 3000) begin
            cycle(1'b1, md);
            n++;
        end
        if (n >= 3000) begin
            chk_cnt++;
            $display("FAIL run_until level=%0d state=%0d not reached", lvl, st);
        end
    endtask

    // monitor: one output snapshot per clock, popped against the scoreboard
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pe/led/state/level", int'({period_end, led, state, level}), int'(e));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // static ON then OFF
        repeat (3 * PER) cycle(1'b1, 2'd1);
        repeat (2 * PER) cycle(1'b1, 2'd0);

        // one full breathe cycle plus margin
        repeat (BCYC * PER + 64) cycle(1'b1, 2'd3);

        // freeze at level 7 while ramping up, then resume
        run_until(2'd3, 7, 1);
        repeat (5 * PER) cycle(1'b0, 2'd3);
        repeat (3 * PER) cycle(1'b1, 2'd3);

        // switch to blink at level 9
        run_until(2'd3, 9, -1);
        repeat (10 * PER) cycle(1'b1, 2'd2);

        // random segments of enable/mode
        repeat (40) begin
            logic       e;
            logic [1:0] md;
            int         len;
            e   = ($urandom_range(0, 3) != 0);
            md  = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 150);
            repeat (len) cycle(e, md);
        end

        // asynchronous reset in the middle of breathing
        repeat (2) cycle(1'b1, 2'd0);
        run_until(2'd3, 5, 1);
        rst_n = 1'b0;
        #1;
        check("reset_led", int'(led), 0);
        check("reset_level", int'(level), 0);
        check("reset_state", int'(state), 0);
        check("reset_period_end", int'(period_end), 0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3 * PER) cycle(1'b1, 2'd3);
        repeat (2 * PER) cycle(1'b1, 2'd1);

        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
